// File: rtl/divider_8b.sv
// divider_8b: 8-bit by 4-bit unsigned restoring divider, one quotient bit per
// clock, MSB first. A request is taken in IDLE or DONE, eight iterations run in
// RUN, and the result is presented with a one-cycle done pulse in DONE.
// Optional feature macro: DIV_ZERO_DETECT_EN (divide-by-zero short-cut and dbz flag).
module divider_8b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] x,
    input  logic [3:0] y,
    output logic       busy,
    output logic       done,
    output logic [7:0] q,
    output logic [3:0] r,
    output logic       dbz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [4:0]  rem_q, rem_d;     // partial remainder
    logic [3:0]  dvs_q, dvs_d;     // latched divisor
    logic [2:0]  cnt_q, cnt_d;     // iteration counter
    logic [7:0]  quo_q, quo_d;     // published quotient
    logic [3:0]  rmd_q, rmd_d;     // published remainder
    logic [4:0]  shifted;
    logic signed [5:0] diff;
    logic        qbit;
    logic [4:0]  rem_next;
    logic [7:0]  dvd_next;
`ifdef DIV_ZERO_DETECT_EN
    logic        dbz_q, dbz_d;
`endif

    // Trial subtraction of the zero-extended divisor; a negative result means restore.
    function automatic logic signed [5:0] trial_sub(input logic [4:0] pr, input logic [3:0] d);
        return $signed({1'b0, pr}) - $signed({2'b00, d});
    endfunction

    // Next-state, iteration datapath and result publication.
    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rmd_d    = rmd_q;
`ifdef DIV_ZERO_DETECT_EN
        dbz_d    = dbz_q;
`endif
        shifted  = {rem_q[3:0], dvd_q[7]};
        diff     = trial_sub(shifted, dvs_q);
        qbit     = ~diff[5];
        rem_next = qbit ? diff[4:0] : shifted;
        dvd_next = {dvd_q[6:0], qbit};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Accept: latch operands and restart the iteration.
                    state_d = RUN;
                    dvd_d   = x;
                    dvs_d   = y;
                    rem_d   = 5'd0;
                    cnt_d   = 3'd0;
`ifdef DIV_ZERO_DETECT_EN
                    dbz_d   = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
`ifdef DIV_ZERO_DETECT_EN
                if (dvs_q == 4'd0) begin
                    state_d = DONE;
                    quo_d   = 8'hFF;
                    rmd_d   = dvd_q[3:0];
                    dbz_d   = 1'b1;
                end else
`endif
                begin
                    dvd_d = dvd_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = DONE;
                        quo_d   = dvd_next;
                        rmd_d   = rem_next[3:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= 8'd0;
            rem_q   <= 5'd0;
            dvs_q   <= 4'd0;
            cnt_q   <= 3'd0;
            quo_q   <= 8'd0;
            rmd_q   <= 4'd0;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign q    = quo_q;
    assign r    = rmd_q;
`ifdef DIV_ZERO_DETECT_EN
    assign dbz  = dbz_q;
`else
    assign dbz  = 1'b0;
`endif

endmodule

// File: tb/tb_divider_8b.sv
// Bench for divider_8b: directed scenarios, held-start streaming, reset abort,
// divide-by-zero handling, randomized and exhaustive checks against x/y, x%y.
module tb_divider_8b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] x;
    logic [3:0] y;
    logic       busy, done, dbz;
    logic [7:0] q;
    logic [3:0] r;

    int n_cmp = 0;
    int n_bad = 0;

    divider_8b dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .q(q), .r(r), .dbz(dbz)
    );

    always #5 clk = ~clk;

    // Reference: arithmetic division; y=0 gives all-ones quotient and low nibble remainder.
    task automatic ref_div(input logic [7:0] a, input logic [3:0] b,
                           output logic [7:0] eq, output logic [3:0] er,
                           output logic edbz, output int elat);
        if (b == 0) begin
            eq = 8'hFF; er = a[3:0];
`ifdef DIV_ZERO_DETECT_EN
            edbz = 1'b1; elat = 2;
`else
            edbz = 1'b0; elat = 9;
`endif
        end else begin
            eq = 8'(int'(a) / int'(b)); er = 4'(int'(a) % int'(b));
            edbz = 1'b0; elat = 9;
        end
    endtask

    // Present a one-cycle start; returns 1 ns after the accept edge.
    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        x = a; y = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Cycle index (accept cycle = 1) at which done is seen; busy cycles counted on the way.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 1; bcnt = 0;
        while (done !== 1'b1 && lat <= 20) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if ({busy, done, dbz} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl got %b want 000", {busy, done, dbz}); end
        n_cmp++; if ({q, r} !== 12'h000) begin n_bad++; $display("FAIL reset_qr got %h want 000", {q, r}); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL idle_ctl got %b want 00", {busy, done}); end
    endtask

    task automatic test_directed;
        int lat, bc;
        launch(8'd225, 4'd15);
        wait_done(lat, bc);
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL d225_lat got %0d want 9", lat); end
        n_cmp++; if (bc != 8) begin n_bad++; $display("FAIL d225_busy got %0d want 8", bc); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL d225_busy_done got %b want 0", busy); end
        n_cmp++; if ({q, r} !== {8'd15, 4'd0}) begin n_bad++; $display("FAIL d225_qr got %0d/%0d want 15/0", q, r); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse got %b want 0", done); end
        launch(8'd100, 4'd7);
        n_cmp++; if ({q, r} !== {8'd15, 4'd0}) begin n_bad++; $display("FAIL hold_qr got %0d/%0d want 15/0", q, r); end
        wait_done(lat, bc);
        n_cmp++; if ({q, r} !== {8'd14, 4'd2}) begin n_bad++; $display("FAIL d100_qr got %0d/%0d want 14/2", q, r); end
        launch(8'd255, 4'd1);
        wait_done(lat, bc);
        n_cmp++; if ({q, r} !== {8'd255, 4'd0}) begin n_bad++; $display("FAIL d255_qr got %0d/%0d want 255/0", q, r); end
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL d255_lat got %0d want 9", lat); end
    endtask

    task automatic test_back_to_back;
        int lat;
        x = 8'd9; y = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            lat = 1;
            while (done !== 1'b1 && lat <= 20) begin
                if (lat == 3) begin x = 8'($urandom); y = 4'($urandom); end
                if (lat == 6) begin x = 8'd9; y = 4'd4; end
                @(posedge clk); #1;
                lat++;
            end
            n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL b2b_lat[%0d] got %0d want 9", k, lat); end
            n_cmp++; if ({q, r} !== {8'd2, 4'd1}) begin n_bad++; $display("FAIL b2b_qr[%0d] got %0d/%0d want 2/1", k, q, r); end
            if (k == 3) start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero;
        int lat, bc, elat;
        logic [7:0] eq; logic [3:0] er; logic ed;
        ref_div(8'd37, 4'd0, eq, er, ed, elat);
        launch(8'd37, 4'd0);
        wait_done(lat, bc);
        n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL dz_lat got %0d want %0d", lat, elat); end
        n_cmp++; if (dbz !== ed) begin n_bad++; $display("FAIL dz_flag got %b want %b", dbz, ed); end
        n_cmp++; if ({q, r} !== {eq, er}) begin n_bad++; $display("FAIL dz_qr got %h/%0d want %h/%0d", q, r, eq, er); end
        launch(8'd10, 4'd3);
        n_cmp++; if (dbz !== 1'b0) begin n_bad++; $display("FAIL dz_clear got %b want 0", dbz); end
        wait_done(lat, bc);
        n_cmp++; if ({q, r} !== {8'd3, 4'd1}) begin n_bad++; $display("FAIL dz_after_qr got %0d/%0d want 3/1", q, r); end
    endtask

    task automatic test_reset_mid_run;
        int lat, bc;
        launch(8'd200, 4'd3);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done, dbz} !== 3'b000) begin n_bad++; $display("FAIL rst_run_ctl got %b want 000", {busy, done, dbz}); end
        n_cmp++; if ({q, r} !== 12'h000) begin n_bad++; $display("FAIL rst_run_qr got %h want 000", {q, r}); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_run_nodone got %b want 0", done); end
        x = 8'd200; y = 4'd3; start = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc);
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL rst_new_lat got %0d want 9", lat); end
        n_cmp++; if ({q, r} !== {8'd66, 4'd2}) begin n_bad++; $display("FAIL rst_new_qr got %0d/%0d want 66/2", q, r); end
    endtask

    task automatic test_random;
        int lat, bc, elat;
        logic [7:0] a, eq; logic [3:0] b, er; logic ed;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            ref_div(a, b, eq, er, ed, elat);
            launch(a, b);
            wait_done(lat, bc);
            n_cmp++; if ({q, r, dbz} !== {eq, er, ed} || lat != elat) begin
                n_bad++; $display("FAIL rand %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=%b lat=%0d",
                                  a, b, q, r, dbz, lat, eq, er, ed, elat);
            end
        end
    endtask

    task automatic test_exhaustive;
        int lat, bc;
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                launch(8'(a), 4'(b));
                wait_done(lat, bc);
                n_cmp++; if (int'(q) != a / b || int'(r) != a % b) begin
                    n_bad++; $display("FAIL exh %0d/%0d got %0d/%0d want %0d/%0d", a, b, q, r, a / b, a % b);
                end
            end
        end
        // Exact products of 4-bit operands must divide back with zero remainder.
        for (int a = 1; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                launch(8'(a * b), 4'(b));
                wait_done(lat, bc);
                n_cmp++; if (int'(q) != a || r !== 4'd0) begin
                    n_bad++; $display("FAIL prod %0d*%0d got %0d/%0d want %0d/0", a, b, q, r, a);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; x = 8'd0; y = 4'd0;
        test_reset;
        test_directed;
        test_back_to_back;
        test_div_zero;
        test_reset_mid_run;
        test_random;
        test_exhaustive;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/divider_8b.md
DIVIDER_8B -- requirements
Module: divider_8b

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-003 SHALL have ports: start  input  1  request; sampled on clk rising edge.
REQ-004 SHALL have ports: x  input  8  dividend, unsigned; same width as the 4x4 multiplier product.
REQ-005 SHALL have ports: y  input  4  divisor, unsigned.
REQ-006 SHALL have ports: busy  output  1  operation in progress.
REQ-007 SHALL have ports: done  output  1  single-cycle completion pulse.
REQ-008 SHALL have ports: q  output  8  quotient.
REQ-009 SHALL have ports: r  output  4  remainder.
REQ-010 SHALL have ports: dbz  output  1  divide-by-zero flag; meaningful only under DIV_ZERO_DETECT_EN.

Function
REQ-011 SHALL compute the restoring unsigned division x = q*y + r with r < y for y != 0, one quotient bit per cycle, MSB first.
- Partial remainder: 5 bits.
- Trial subtract of {1'b0,y}; keep the difference if it is non-negative, otherwise restore.
REQ-012 SHALL use a three-state FSM with states IDLE, RUN and DONE.
- IDLE->RUN: start=1.
- RUN->DONE: after the 8th iteration.
- DONE->RUN: start=1, otherwise DONE->IDLE.
REQ-013 SHALL accept a request when start=1 in IDLE or DONE, latching x and y at that edge (E0).
REQ-014 SHALL ignore start while in RUN; the latched operands SHALL NOT change.
REQ-015 SHALL perform iterations on edges E1..E8 and update q/r only at E8; done=1 for exactly the cycle after E8.
REQ-016 SHALL drive busy=1 from E0 until E8, and busy=0 in the done cycle.
REQ-017 SHALL hold q/r stable from E8 until the next result is written; a new start does not clear them.
REQ-018 SHALL support back-to-back operation: start accepted in the done cycle gives the next done 9 cycles later.
REQ-019 SHALL produce q=8'hFF, r=x[3:0] for y=0 when DIV_ZERO_DETECT_EN is undefined, with normal 8-iteration latency and dbz=0.
REQ-020 SHALL treat x=0 with y!=0 as a normal 8-iteration operation producing q=0, r=0.

Reset
REQ-021 SHALL, on rst_n=0, immediately force state=IDLE, busy=0, done=0, q=0, r=0, dbz=0 and iteration counter=0.
REQ-022 SHALL, on reset during RUN, abandon the operation; no done is produced for it.
REQ-023 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL compile divide-by-zero detection in only when the macro DIV_ZERO_DETECT_EN is defined.
- Defined, y=0 at accept: RUN is skipped and the block enters DONE at E1.
- In that case q=8'hFF, r=x[3:0], dbz=1 and done is asserted in the cycle after E1.
- dbz is cleared at the next accept.
REQ-025 SHALL, when DIV_ZERO_DETECT_EN is undefined, tie dbz to 0 and apply REQ-019 behaviour.

Verification
REQ-026 SHALL cover: x=8'd225, y=4'd15, start pulse -> done 9 cycles after the accept edge, q=15, r=0, busy high for 8 cycles.
REQ-027 SHALL cover: x=8'd100, y=4'd7 -> q=14, r=2; then x=8'd255, y=4'd1 -> q=255, r=0.
REQ-028 SHALL cover: start held high continuously with x=8'd9, y=4'd4 -> done every 9 cycles, q=2, r=1 each time, with mid-RUN operand changes ignored.
REQ-029 SHALL cover: x=8'd37, y=4'd0 -> with the macro: done 2 cycles after accept, dbz=1, q=8'hFF, r=5; without it: done after 9 cycles, dbz=0, q=8'hFF, r=5.
REQ-030 SHALL cover: rst_n pulsed low at iteration 4 of x=8'd200, y=4'd3 -> outputs zero immediately, no done pulse; a new request x=8'd200, y=4'd3 -> q=66, r=2.
REQ-031 SHALL cover: an exhaustive check of all 256x15 nonzero operand pairs against x/y and x%y, and against products of 4x4 operands.
